exp_req_scheduler: RTL and testbench

Round-robin scheduler that shares one fixed-point exponent datapath among NUM_REQ requesters. It accepts Q4.4 operands over per-requester valid/ready and drives them into the exponent unit one per cycle. It tracks each operand through the unit's fixed latency with a tag pipeline and returns each Q17.28 result to the requester that issued it. The scheduler sits between the requesting engines and the exponent instance, which stays outside this block.

---
 rtl/exp_sched_pkg.sv | 22 ++
 rtl/exp_req_scheduler_rr_arbiter.sv | 31 +++
 rtl/exp_req_scheduler.sv | 101 ++++++++++
 tb/tb_exp_req_scheduler.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_sched_pkg.sv
// Shared types for the exponent request scheduler.
// Operand/result formats and the in-flight tag record.
package exp_sched_pkg;

  localparam int IN_W     = 8;
  localparam int IN_INT   = 4;
  localparam int IN_FRAC  = 4;
  localparam int OUT_W    = 45;
  localparam int OUT_INT  = 17;
  localparam int OUT_FRAC = 28;
  localparam int MAX_REQ  = 8;
  localparam int IDX_W    = $clog2(MAX_REQ);

  typedef logic [IN_W-1:0]  q4_4_t;
  typedef logic [OUT_W-1:0] q17_28_t;

  typedef struct packed {
    logic             v;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/exp_req_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
// Ports: req/ptr in, one-hot grant, winner idx and any-grant flag out.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int c;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int o = 0; o < N; o++) begin
      c = (int'(ptr) + o) % N;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/exp_req_scheduler.sv
// Shares one exponent unit among NUM_REQ requesters, returning results by tag.
// Ports: req_* operand handshake, rsp_* result handshake, exp_* unit link, idle.
module exp_req_scheduler
  import exp_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int EXP_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IN_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [NUM_REQ*OUT_W-1:0] rsp_data,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output q4_4_t                    exp_inp,
  input  q17_28_t                  exp_outp,
  output logic                     idle
);

  localparam int IW = $clog2(NUM_REQ);
  // Stage 0 rides alongside exp_inp; the last stage lines up
  // with the edge where exp_outp holds that operand's result.
  localparam int DEPTH = EXP_LAT + 1;

  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] acc;
  logic [NUM_REQ-1:0] cap;
  logic [NUM_REQ-1:0] rv_nxt;
  logic [NUM_REQ-1:0] busy_nxt;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      win;
  logic               any;
  logic               fly;
  logic               idle_nxt;
  q4_4_t              op;
  tag_t               tags [DEPTH];

  // Reset also blocks grants so nothing handshakes while held.
  assign elig = {NUM_REQ{en & rst}} & req_valid & ~busy;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (elig),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  assign req_ready = grant;

  always_comb begin
    op  = '0;
    cap = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) op = req_data[i*IN_W +: IN_W];
      cap[i] = tags[DEPTH-1].v &&
               (tags[DEPTH-1].idx == IDX_W'(i));
    end
    acc      = rsp_valid & rsp_ready;
    rv_nxt   = (rsp_valid & ~acc) | cap;
    busy_nxt = (busy & ~acc) | grant;
    fly      = any;
    for (int s = 0; s < DEPTH-1; s++)
      fly = fly | tags[s].v;
    idle_nxt = ~fly & ~|rv_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < DEPTH; s++)
        tags[s] <= '0;
      busy      <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      exp_inp   <= '0;
      ptr       <= '0;
      idle      <= 1'b0;
    end else begin
      tags[0] <= '{v: any, idx: IDX_W'(win)};
      for (int s = 1; s < DEPTH; s++)
        tags[s] <= tags[s-1];
      if (any) begin
        exp_inp <= op;
        ptr     <= (win == IW'(NUM_REQ-1)) ?
                   '0 : win + 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (cap[i])
          rsp_data[i*OUT_W +: OUT_W] <= exp_outp;
      busy      <= busy_nxt;
      rsp_valid <= rv_nxt;
      idle      <= idle_nxt;
    end
  end

endmodule

// File: tb/tb_exp_req_scheduler.sv
// Randomised bench for exp_req_scheduler against a queue-based model.
// Includes a behavioural exponent unit with a two-edge latency.
module tb_exp_req_scheduler;
  import exp_sched_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 2;
  localparam real SC = 268435456.0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic [N-1:0]       req_valid = '0;
  logic [N-1:0]       rsp_ready = '0;
  logic [N*IN_W-1:0]  req_data  = '0;
  logic [N-1:0]       req_ready;
  logic [N-1:0]       rsp_valid;
  logic [N*OUT_W-1:0] rsp_data;
  q4_4_t   exp_inp;
  q17_28_t exp_outp;
  logic    idle;
  q17_28_t e1, e2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  exp_req_scheduler #(.NUM_REQ(N), .EXP_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .exp_inp   (exp_inp),
    .exp_outp  (exp_outp),
    .idle      (idle)
  );

  function automatic q17_28_t exp_fn(q4_4_t q);
    real x;
    x = real'($signed(q)) / 16.0;
    return q17_28_t'(longint'($exp(x) * SC));
  endfunction

  always @(posedge clk) begin
    e1 <= exp_fn(exp_inp);
    e2 <= e1;
  end
  assign exp_outp = e2;

  // ---- reference model ----
  typedef struct {
    int    idx;
    q4_4_t d;
    int    age;
  } fl_t;

  typedef struct packed {
    logic [N-1:0]       rdy;
    logic [N-1:0]       rv;
    logic [N*OUT_W-1:0] rd;
    logic               idle;
  } snap_t;

  int       m_ptr;
  logic [N-1:0] m_busy, m_rv;
  q17_28_t  m_rd [N];
  fl_t      fl [$];

  task automatic model_reset();
    m_ptr  = 0;
    m_busy = '0;
    m_rv   = '0;
    foreach (m_rd[i]) m_rd[i] = '0;
    fl.delete();
  endtask

  function automatic int pick();
    int c;
    for (int o = 0; o < N; o++) begin
      c = (m_ptr + o) % N;
      if (en && req_valid[c] && !m_busy[c])
        return c;
    end
    return -1;
  endfunction

  // Entered at posedge+1 with inputs driven; leaves at next posedge+1.
  task automatic step(output snap_t g, output snap_t e);
    int   w;
    fl_t  keep [$];
    #1;
    w = pick();
    g.rdy = req_ready;
    e.rdy = (w >= 0) ? N'(1) << w : '0;
    for (int i = 0; i < N; i++)
      if (m_rv[i] && rsp_ready[i]) begin
        m_rv[i]   = 1'b0;
        m_busy[i] = 1'b0;
      end
    foreach (fl[k]) begin
      if (fl[k].age == LAT) begin
        m_rv[fl[k].idx] = 1'b1;
        m_rd[fl[k].idx] = exp_fn(fl[k].d);
      end else begin
        keep.push_back('{fl[k].idx, fl[k].d, fl[k].age + 1});
      end
    end
    fl = keep;
    if (w >= 0) begin
      fl.push_back('{w, req_data[w*IN_W +: IN_W], 0});
      m_busy[w] = 1'b1;
      m_ptr     = (w + 1) % N;
    end
    @(posedge clk);
    #1;
    g.rv   = rsp_valid;
    g.rd   = rsp_data;
    g.idle = idle;
    e.rv   = m_rv;
    for (int i = 0; i < N; i++)
      e.rd[i*OUT_W +: OUT_W] = m_rd[i];
    e.idle = (fl.size() == 0) && (m_rv == '0);
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (rsp_valid !== '0) begin
      n_fail++;
      $display("FAIL reset_rv got %h want 0", rsp_valid);
    end
    n_tests++;
    if (req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_rdy got %h want 0", req_ready);
    end
    n_tests++;
    if (idle !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle got %b want 0", idle);
    end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_all_four();
    snap_t g, e;
    real   want [N];
    real   got;
    want = '{1.0, 1.6487212707, 2.7182818285, 4.4816890703};
    en        = 1'b1;
    rsp_ready = '0;
    req_valid = '1;
    req_data  = {8'h18, 8'h10, 8'h08, 8'h00};
    for (int s = 0; s < 7; s++) begin
      step(g, e);
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL all4 s%0d got %h want %h", s, g, e);
      end
      if (s < N) begin
        n_tests++;
        if (g.rdy !== N'(1) << s) begin
          n_fail++;
          $display("FAIL all4_order s%0d got %b want %b",
                   s, g.rdy, N'(1) << s);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      got = real'(rsp_data[i*OUT_W +: OUT_W]) / SC;
      n_tests++;
      if (got - want[i] > 1.0/65536.0 ||
          want[i] - got > 1.0/65536.0) begin
        n_fail++;
        $display("FAIL all4_val r%0d got %f want %f",
                 i, got, want[i]);
      end
    end
    req_valid = '0;
    rsp_ready = '1;
    step(g, e);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL all4_acc got %h want %h", g, e);
    end
    rsp_ready = '0;
  endtask

  task automatic test_single();
    snap_t  g, e;
    longint d;
    req_valid      = 4'b0001;
    req_data[7:0]  = 8'h10;
    step(g, e);
    n_tests++;
    if (g.rdy !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_rdy got %b want 0001", g.rdy);
    end
    n_tests++;
    if (exp_inp !== 8'h10) begin
      n_fail++;
      $display("FAIL single_inp got %h want 10", exp_inp);
    end
    req_valid = '0;
    for (int k = 1; k <= 3; k++) begin
      step(g, e);
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL single k%0d got %h want %h", k, g, e);
      end
    end
    n_tests++;
    if (rsp_valid[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_lat got %b want 1", rsp_valid[0]);
    end
    d = longint'(rsp_data[OUT_W-1:0]) - 64'h2B7E1516;
    n_tests++;
    if (d > 4096 || d < -4096) begin
      n_fail++;
      $display("FAIL single_e got %h want ~2b7e1516",
               rsp_data[OUT_W-1:0]);
    end
    rsp_ready = '1;
    step(g, e);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL single_acc got %h want %h", g, e);
    end
    rsp_ready = '0;
  endtask

  task automatic test_backpressure();
    snap_t   g, e;
    bit      had1 = 0;
    q17_28_t hold1 = '0;
    bit      cap1 = 0;
    req_valid = '1;
    rsp_ready = 4'b1101;
    for (int s = 0; s < 20; s++) begin
      req_data = N*IN_W'($urandom);
      step(g, e);
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL bp s%0d got %h want %h", s, g, e);
      end
      n_tests++;
      if (had1 && g.rdy[1]) begin
        n_fail++;
        $display("FAIL bp_regrant s%0d got 1 want 0", s);
      end
      if (g.rdy[1]) had1 = 1;
      if (cap1) begin
        n_tests++;
        if (rsp_data[OUT_W +: OUT_W] !== hold1) begin
          n_fail++;
          $display("FAIL bp_stable got %h want %h",
                   rsp_data[OUT_W +: OUT_W], hold1);
        end
      end else if (rsp_valid[1]) begin
        cap1  = 1;
        hold1 = rsp_data[OUT_W +: OUT_W];
      end
    end
    rsp_ready = '1;
    step(g, e);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL bp_rel got %h want %h", g, e);
    end
    req_valid = 4'b0010;
    step(g, e);
    n_tests++;
    if (g.rdy !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_again got %b want 0010", g.rdy);
    end
  endtask

  task automatic test_fairness();
    snap_t g, e;
    int cnt [2] = '{0, 0};
    int wt  [2] = '{0, 0};
    int last = -1;
    logic [N-1:0] pre;
    req_valid = '0;
    rsp_ready = '1;
    for (int s = 0; s < 6; s++) begin
      step(g, e);
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL fair_dr s%0d got %h want %h", s, g, e);
      end
    end
    req_valid = 4'b0011;
    for (int c = 0; c < 100; c++) begin
      req_data = N*IN_W'($urandom);
      pre = req_valid & ~m_busy;
      step(g, e);
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL fair c%0d got %h want %h", c, g, e);
      end
      for (int r = 0; r < 2; r++) begin
        if (g.rdy[r]) begin
          cnt[r]++;
          n_tests++;
          if (last == r) begin
            n_fail++;
            $display("FAIL fair_alt c%0d got r%0d want r%0d",
                     c, r, 1 - r);
          end
          last  = r;
          wt[r] = 0;
        end else if (pre[r]) begin
          wt[r]++;
          n_tests++;
          if (wt[r] > 1) begin
            n_fail++;
            $display("FAIL fair_wait c%0d r%0d got %0d want <=1",
                     c, r, wt[r]);
          end
        end
      end
    end
    n_tests++;
    if (cnt[0] - cnt[1] > 1 || cnt[1] - cnt[0] > 1) begin
      n_fail++;
      $display("FAIL fair_cnt got %0d/%0d want diff<=1",
               cnt[0], cnt[1]);
    end
  endtask

  task automatic test_drain();
    snap_t g, e;
    int    held;
    bit    done = 0;
    req_valid = '0;
    rsp_ready = '1;
    for (int s = 0; s < 6; s++) step(g, e);
    req_valid = 4'b1100;
    for (int s = 0; s < 2; s++) begin
      step(g, e);
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL drain_go s%0d got %h want %h", s, g, e);
      end
    end
    en   = 1'b0;
    req_valid = '1;
    held = m_ptr;
    for (int s = 0; s < 10 && !done; s++) begin
      step(g, e);
      n_tests++;
      if (g.rdy !== '0 || g !== e) begin
        n_fail++;
        $display("FAIL drain s%0d got %h want %h", s, g, e);
      end
      if (g.idle) done = 1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_idle got 0 want 1 within 10");
    end
    en = 1'b1;
    step(g, e);
    n_tests++;
    if (g.rdy !== N'(1) << held) begin
      n_fail++;
      $display("FAIL drain_resume got %b want %b",
               g.rdy, N'(1) << held);
    end
  endtask

  task automatic test_reset_mid();
    snap_t g, e;
    req_valid = '1;
    rsp_ready = '0;
    en        = 1'b1;
    repeat (3) step(g, e);
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (rsp_valid !== '0 || req_ready !== '0 ||
        idle !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid got rv=%h rdy=%h idle=%b want 0/0/0",
               rsp_valid, req_ready, idle);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    step(g, e);
    n_tests++;
    if (g.rdy !== 4'b0001) begin
      n_fail++;
      $display("FAIL rmid_first got %b want 0001", g.rdy);
    end
    req_valid = '0;
    for (int s = 0; s < 5; s++) begin
      step(g, e);
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL rmid s%0d got %h want %h", s, g, e);
      end
    end
  endtask

  task automatic test_random();
    snap_t g, e;
    for (int s = 0; s < 300; s++) begin
      en        = ($urandom_range(0, 9) != 0);
      req_valid = N'($urandom);
      rsp_ready = N'($urandom);
      req_data  = N*IN_W'($urandom);
      step(g, e);
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL rand s%0d got %h want %h", s, g, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all_four();
    test_single();
    test_backpressure();
    test_fairness();
    test_drain();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
